// File: rtl/clock_pkg.sv
// Shared types and constants for the clock display datapath.
//   BCD_W        : bits per BCD digit
//   bcd_digit_t  : one packed BCD digit
//   state_t      : sequential converter control states
//   BCD_NINE     : digit value used when saturating on overflow
package clock_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
//   din  : current BCD digit (0-9)
//   dout : corrected digit (0-4 unchanged, 5-9 become 8-12)
module bcd_add3
  import clock_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  always_comb begin
    dout = din;
    if (din >= bcd_digit_t'(5)) begin
      dout = din + bcd_digit_t'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one iteration per clock)
// with valid/ready handshakes and saturation when the value needs more than
// DIGITS decimal digits.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake; bin sampled on the accept edge
//   bin                 : unsigned binary value, BIN_W bits
//   out_valid/out_ready : output handshake; result held until accepted
//   bcd                 : packed BCD, digit k at [4k+3:4k]
//   ovf                 : value exceeded 10^DIGITS-1, bcd forced to all 9s
module bin_to_bcd_seq
  import clock_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic                      ovf
);

  localparam int unsigned BCD_TOT = BCD_W * DIGITS;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);

  state_t               state;
  logic [BIN_W-1:0]     sh;
  logic [BCD_TOT-1:0]   acc;
  logic [BCD_TOT-1:0]   adj;
  logic [BCD_TOT-1:0]   acc_nx;
  logic [BIN_W-1:0]     sh_nx;
  logic                 carry;
  logic                 sticky;
  logic                 sticky_nx;
  logic [CNT_W-1:0]     cnt;
  logic [BCD_TOT-1:0]   bcd_sat;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc[g*BCD_W +: BCD_W]),
      .dout (adj[g*BCD_W +: BCD_W])
    );
  end

  // One iteration: corrected digits and the binary register shift as a
  // single word; the bit leaving the top digit means the value no longer
  // fits and is folded into the sticky overflow flag.
  always_comb begin
    {carry, acc_nx, sh_nx} = {adj, sh, 1'b0};
    sticky_nx              = sticky | carry;
    bcd_sat                = {DIGITS{BCD_NINE}};
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      cnt       <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh     <= bin;
            acc    <= '0;
            sticky <= 1'b0;
            cnt    <= CNT_W'(BIN_W);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sh     <= sh_nx;
          acc    <= acc_nx;
          sticky <= sticky_nx;
          cnt    <= cnt - CNT_W'(1);
          // Last iteration: publish the result on the same edge.
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ovf       <= sticky_nx;
            bcd       <= sticky_nx ? bcd_sat : acc_nx;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: BIN_W=14, DIGITS=4
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [13:0] a_bin;
  logic [15:0] a_bcd;

  // Instance B: BIN_W=6, DIGITS=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [5:0]  b_bin;
  logic [7:0]  b_bcd;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .bin(a_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd(a_bcd), .ovf(a_ovf)
  );

  bin_to_bcd_seq #(.BIN_W(6), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .bin(b_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd(b_bcd), .ovf(b_ovf)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: decimal digits by division, saturating above 10^d-1.
  function automatic void ref_conv(input longint unsigned v, input int unsigned d,
                                   output logic [63:0] b, output logic o);
    longint unsigned lim = 1;
    longint unsigned t;
    for (int k = 0; k < int'(d); k++) lim = lim * 10;
    b = '0;
    o = (v > lim - 1);
    t = v;
    for (int k = 0; k < int'(d); k++) begin
      b[4*k +: 4] = o ? 4'd9 : 4'(t % 10);
      t = t / 10;
    end
  endfunction

  task automatic conv_a(input logic [13:0] v, output logic [15:0] rb, output logic ro,
                        output int lat);
    int w = 0;
    while (!a_in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!a_in_ready) chk("a_in_ready_timeout", 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b1;
    a_bin      = v;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_bin      = 14'($urandom);
    lat = 1;
    while (!a_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    rb = a_bcd;
    ro = a_ovf;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic conv_b(input logic [5:0] v, output logic [7:0] rb, output logic ro,
                        output int lat);
    int w = 0;
    while (!b_in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!b_in_ready) chk("b_in_ready_timeout", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b1;
    b_bin      = v;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_bin      = 6'($urandom);
    lat = 1;
    while (!b_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    rb = b_bcd;
    ro = b_ovf;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  task automatic wait_a_valid();
    int w = 0;
    while (!a_out_valid && w < 200) begin @(posedge clk); #1; w++; end
    if (!a_out_valid) chk("a_out_valid_timeout", 64'(a_out_valid), 64'd1);
  endtask

  typedef struct {
    logic [13:0] v;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t        tbl[13];
  logic [15:0] rb;
  logic [7:0]  rb6;
  logic        ro;
  int          lat;
  logic [63:0] eb;
  logic        eo;
  logic [15:0] res[$];
  int          acc_at[2];
  int          nacc;
  logic        will_acc, will_res;
  logic [15:0] snap;
  int          bad;
  logic [13:0] rv;

  initial begin
    tbl[0]  = '{14'd9999,  16'h9999, 1'b0};
    tbl[1]  = '{14'd0,     16'h0000, 1'b0};
    tbl[2]  = '{14'd1234,  16'h1234, 1'b0};
    tbl[3]  = '{14'd10000, 16'h9999, 1'b1};
    tbl[4]  = '{14'd16383, 16'h9999, 1'b1};
    tbl[5]  = '{14'd42,    16'h0042, 1'b0};
    tbl[6]  = '{14'd1,     16'h0001, 1'b0};
    tbl[7]  = '{14'd9,     16'h0009, 1'b0};
    tbl[8]  = '{14'd10,    16'h0010, 1'b0};
    tbl[9]  = '{14'd99,    16'h0099, 1'b0};
    tbl[10] = '{14'd100,   16'h0100, 1'b0};
    tbl[11] = '{14'd5678,  16'h5678, 1'b0};
    tbl[12] = '{14'd8191,  16'h8191, 1'b0};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_bin = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_bin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(a_in_ready),  64'd1);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_bcd",       64'(a_bcd),       64'd0);
    chk("rst_ovf",       64'(a_ovf),       64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    rst_n = 1'b1;

    // Table vectors, including latency and post-handshake ready
    for (int i = 0; i < 13; i++) begin
      conv_a(tbl[i].v, rb, ro, lat);
      chk($sformatf("tbl%0d_bcd", i), 64'(rb), 64'(tbl[i].bcd));
      chk($sformatf("tbl%0d_ovf", i), 64'(ro), 64'(tbl[i].ovf));
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd15);
      chk($sformatf("tbl%0d_rdy", i), 64'({a_in_ready, a_out_valid}), 64'b10);
    end

    // Back-to-back: in_valid held, out_ready held
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_bin       = 14'd0;
    nacc = 0;
    for (int c = 0; c < 80 && res.size() < 2; c++) begin
      will_acc = a_in_valid && a_in_ready;
      will_res = a_out_valid && a_out_ready;
      snap     = a_bcd;
      @(posedge clk); #1;
      if (will_res) res.push_back(snap);
      if (will_acc) begin
        if (nacc < 2) acc_at[nacc] = c;
        nacc++;
        if (nacc == 1) a_bin = 14'd1234;
        else a_in_valid = 1'b0;
      end
    end
    a_in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    chk("b2b_accepts", 64'(nacc), 64'd2);
    chk("b2b_results", 64'(res.size()), 64'd2);
    if (res.size() >= 2) begin
      chk("b2b_res0", 64'(res[0]), 64'h0000);
      chk("b2b_res1", 64'(res[1]), 64'h1234);
    end
    if (nacc >= 2) chk("b2b_gap", 64'(acc_at[1] - acc_at[0]), 64'd16);
    chk("b2b_no_dup", 64'(a_out_valid), 64'd0);

    // Stall: result held with out_ready low while a new input waits
    a_in_valid = 1'b1;
    a_bin      = 14'd321;
    @(posedge clk); #1;
    a_bin = 14'd42;
    wait_a_valid();
    snap = a_bcd;
    bad  = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!a_out_valid || a_bcd !== snap || a_in_ready) bad++;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    chk("stall_bcd", 64'(snap), 64'h0321);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk("stall_release_rdy", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk("stall_accept42", 64'(a_in_ready), 64'd0);
    wait_a_valid();
    chk("stall_bcd42", 64'(a_bcd), 64'h0042);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;

    // Reset during iteration 7 of 5678
    a_in_valid = 1'b1;
    a_bin      = 14'd5678;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
    chk("midrst_bcd",       64'(a_bcd),       64'd0);
    chk("midrst_ovf",       64'(a_ovf),       64'd0);
    chk("midrst_in_ready",  64'(a_in_ready),  64'd1);
    bad = 0;
    repeat (30) begin @(posedge clk); #1; if (a_out_valid) bad++; end
    chk("midrst_no_result", 64'(bad), 64'd0);
    conv_a(14'd77, rb, ro, lat);
    chk("after_rst_77", 64'(rb), 64'h0077);
    chk("after_rst_77_ovf", 64'(ro), 64'd0);

    // Randomised against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rv = 14'($urandom_range(0, 16383));
      conv_a(rv, rb, ro, lat);
      ref_conv(64'(rv), 4, eb, eo);
      chk($sformatf("rand_bcd_%0d", rv), 64'(rb), eb);
      chk($sformatf("rand_ovf_%0d", rv), 64'(ro), 64'(eo));
    end

    // Narrow instance: full sweep
    for (int v = 0; v < 64; v++) begin
      conv_b(6'(v), rb6, ro, lat);
      ref_conv(64'(v), 2, eb, eo);
      chk($sformatf("b_bcd_%0d", v), 64'(rb6), eb);
      chk($sformatf("b_ovf_%0d", v), 64'(ro), 64'd0);
      chk($sformatf("b_lat_%0d", v), 64'(lat), 64'd7);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter. It runs a sequential double-dabble: one shift/add-3 iteration per clock. It replaces the fixed 6-bit, 2-digit combinational converters used in the clock display path for wider fields such as year (0-9999) and day-of-year. It has a valid/ready handshake on both sides, plus overflow saturation when the value does not fit in DIGITS decimal digits.

Parameters:
BIN_W, 14, width of binary input (>=1, <=32)
DIGITS, 4, number of BCD output digits (>=1, <=10)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  bin is valid this cycle
in_ready  output  1  block can accept a new value (IDLE only)
bin  input  BIN_W  unsigned binary value
out_valid  output  1  bcd/ovf valid, held until accepted
out_ready  input  1  consumer accepts result
bcd  output  4*DIGITS  packed BCD; bits [3:0] = ones digit, [4k+3:4k] = digit k
ovf  output  1  value > 10^DIGITS-1; bcd saturated to all 9s

Behaviour:
- Reset: clk and rst_n are the only clock/reset; reset is synchronous, active-low. While rst_n=0 at a rising edge: state=IDLE, in_ready=1 (combinational from state), out_valid=0, bcd=0, ovf=0, shift/BCD work registers and iteration counter cleared.
- Reset mid-conversion or while holding a result: the conversion is discarded; no out_valid pulse follows.
- FSM states IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid=1: capture bin into the shift register, clear the BCD accumulator and sticky overflow, load counter=BIN_W, go to SHIFT.
- SHIFT: in_ready=0, out_valid=0. On each edge:
  - Every digit >=5 is given +3 (digit values 0-9 only; 5..9 map to 8..12).
  - The combined {BCD, bin} register shifts left by 1.
  - The bit shifted out of the top digit ORs into sticky ovf.
  - The counter decrements. After the edge that takes the counter to 0, go to DONE.
- Latency: out_valid=1 exactly BIN_W+1 rising edges after the accept edge (1 load edge + BIN_W iteration edges). The final iteration edge also registers the bcd/ovf outputs.
- DONE: out_valid=1, bcd/ovf stable. On out_ready=1, go to IDLE; out_valid=0 and in_ready=1 from the next cycle. With out_ready held 1, throughput is one conversion per BIN_W+2 cycles.
- in_valid while not in IDLE is ignored (no queueing). bin is sampled only on the accept edge and may change afterwards.
- Overflow: if sticky ovf=1 at completion, bcd is forced to all digits 4'd9 and ovf=1. Otherwise bcd holds the exact conversion and ovf=0.
- If 10^DIGITS > 2^BIN_W-1, ovf can never assert; this is legal.
- bcd and ovf only change on the completion edge and on reset. They hold their last value in IDLE and SHIFT; out_valid qualifies them.
- All arithmetic is unsigned. There are no intermediate digit values >15; the add-3 is applied only to digits >=5, pre-shift.

Decomposition:
- Shared package clock_pkg: BCD_W=4 constant; bcd_digit_t (4-bit) typedef; state enum {IDLE, SHIFT, DONE}; BCD_NINE=4'd9 constant.
- Sub-module bcd_add3 (4-bit in to 4-bit out, combinational: in>=5 ? in+3 : in), instantiated DIGITS times via generate.
- Counter width is $clog2(BIN_W+1).

Test Plan:
- BIN_W=14, DIGITS=4, bin=9999, out_ready=1 -> out_valid exactly 15 edges after accept; bcd=16'h9999, ovf=0; in_ready back to 1 the cycle after the handshake.
- bin=0 then bin=1234 back-to-back (in_valid held) -> bcd=16'h0000 then 16'h1234, ovf=0; second accept happens only after the first result handshake; no lost or duplicated results.
- bin=10000 and bin=16383 -> bcd=16'h9999, ovf=1 for both.
- out_ready=0 for 20 cycles after completion, with in_valid=1 and bin=42 -> bcd/out_valid stay stable; in_ready=0; 42 is accepted only after out_ready pulses.
- rst_n=0 for 1 cycle at iteration 7 of bin=5678 -> out_valid, bcd and ovf all 0; no result emitted; a new conversion of 77 then gives 16'h0077.
- Second instance BIN_W=6, DIGITS=2: sweep bin 0..63 -> for 0..31 the tens/ones match the existing 1-31 converter; for 0..63, ovf=0 and the correct BCD; latency 7 edges.
